// File: rtl/router_in_port_pkg.sv
// router_in_port_pkg: shared NoC router types, constants and the routing table.
package router_in_port_pkg;
    localparam int NUM_PORTS = 4;
    localparam int MAX_NODE = 5;
    localparam int PORT_W = $clog2(NUM_PORTS);

    typedef struct packed {
        logic [3:0]  src;
        logic [3:0]  dest;
        logic [23:0] data;
    } pkt_t;

    typedef struct packed {
        logic              ok;
        logic [PORT_W-1:0] port;
    } route_t;

    typedef enum logic [1:0] {IDLE, B1, B2, B3} state_t;

    function automatic route_t route_port(input int routerid, input logic [3:0] dest);
        route_port = '0;
        if (dest <= 4'(MAX_NODE)) begin
            if (routerid == 0) begin
                route_port.ok = 1'b1;
                route_port.port = dest == 4'd0 ? 2'd0 : dest == 4'd1 ? 2'd2 : dest == 4'd2 ? 2'd3 : 2'd1;
            end else if (routerid == 1) begin
                route_port.ok = 1'b1;
                route_port.port = dest < 4'd3 ? 2'd3 : dest == 4'd3 ? 2'd0 : dest == 4'd4 ? 2'd1 : 2'd2;
            end
        end
    endfunction
endpackage

// File: rtl/router_in_port_fifo.sv
// pkt_fifo: circular packet buffer with power-of-two depth and wrapping pointers.
module pkt_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 34,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             we,
    input  logic             re,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic wr, rd;

    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
    assign wr = we && !full;
    assign rd = re && !empty;
    assign data_out = mem[rp];

    always_ff @(posedge clock) begin
        if (reset) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
        end else begin
            wp <= wp + AW'(wr);
            rp <= rp + AW'(rd);
            count <= count + CW'(wr) - CW'(rd);
            if (wr)
                mem[wp] <= data_in;
        end
    end
endmodule

// File: rtl/router_in_port.sv
// router_in_port: deserialises 4-byte node packets, routes them and buffers them for the switch.
module router_in_port
    import router_in_port_pkg::*;
#(
    parameter int ROUTERID = 0,
    parameter int DEPTH = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              put_inbound,
    input  logic [7:0]        payload_inbound,
    output logic              free_inbound,
    output logic              pkt_valid,
    output pkt_t              pkt,
    output logic [PORT_W-1:0] pkt_port,
    input  logic              pkt_ready,
    output logic              err_drop
);
    localparam int CW = $clog2(DEPTH) + 1;

    state_t state, next;
    logic [7:0] hdr, b1, b2;
    logic push, drop, empty, full;
    logic [CW-1:0] count;
    logic [PORT_W+31:0] head;
    route_t rt;

    assign rt = route_port(ROUTERID, hdr[3:0]);
    assign free_inbound = (state == IDLE) && (count < CW'(DEPTH));
    assign pkt_valid = !empty;
    assign {pkt_port, pkt} = head;

    pkt_fifo #(.DEPTH(DEPTH), .WIDTH(PORT_W + 32)) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .data_in  ({rt.port, hdr, b1, b2, payload_inbound}),
        .we       (push),
        .re       (pkt_valid && pkt_ready),
        .data_out (head),
        .full     (full),
        .empty    (empty),
        .count    (count)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            hdr <= '0;
            b1 <= '0;
            b2 <= '0;
            err_drop <= 1'b0;
        end else begin
            state <= next;
            err_drop <= drop;
            if (state == IDLE && put_inbound && free_inbound)
                hdr <= payload_inbound;
            if (state == B1 && put_inbound)
                b1 <= payload_inbound;
            if (state == B2 && put_inbound)
                b2 <= payload_inbound;
        end
    end

    // Last byte comes straight from the link, so the push lands on the edge ending B3.
    always_comb begin
        next = state;
        case (state)
            IDLE: next = put_inbound && free_inbound ? B1 : IDLE;
            B1:   next = put_inbound ? B2 : IDLE;
            B2:   next = put_inbound ? B3 : IDLE;
            B3:   next = IDLE;
        endcase
        push = state == B3 && put_inbound && rt.ok && !full;
        drop = state != IDLE && (!put_inbound || (state == B3 && !rt.ok));
    end
endmodule
